// File: rtl/axis_pkg.sv
// Shared types and default geometry for the AXI-Stream frame sink.
package axis_pkg;

  typedef enum logic {
    RECV    = 1'b0,
    DISCARD = 1'b1
  } frame_sink_state_t;

  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;

endpackage

// File: rtl/axis_raster_counter.sv
// Row/column raster position counter with enable, synchronous clear and
// first/last position flags.
module axis_raster_counter
  import axis_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en_i,
  input  logic                     clr_i,
  output logic [$clog2(IMG_H)-1:0] row_o,
  output logic [$clog2(IMG_W)-1:0] col_o,
  output logic                     at_first_o,
  output logic                     at_last_o
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  // Clear wins over enable so a frame-ending beat always restarts at (0,0).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o      = row_q;
  assign col_o      = col_q;
  assign at_first_o = (row_q == '0) && (col_q == '0);
  assign at_last_o  = (row_q == ROW_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/axis_frame_sink.sv
// AXI-Stream frame sink: tags raster pixels with coordinates and forwards them
// through one registered stage. Define AXIS_FRAME_SINK_TLAST_CHECK_EN for tlast framing checks.
module axis_frame_sink
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int CNT_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic                          s_tkeep,
  input  logic [$clog2(DATA_WIDTH)-1:0] s_tstrb,
  input  logic                          s_tlast,
  output logic [DATA_WIDTH-1:0]         pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(IMG_H)-1:0]      pix_row,
  output logic [$clog2(IMG_W)-1:0]      pix_col,
  output logic                          pix_first,
  output logic                          pix_last,
  output logic                          frame_done,
  output logic                          err_early_last,
  output logic                          err_missing_last,
  output logic [CNT_W-1:0]              frame_count
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  at_first, at_last;
  logic                  accept, in_recv, kept, early, missing, cnt_clr, out_hs;
  logic                  unused_inputs;

  logic [DATA_WIDTH-1:0] pix_data_q;
  logic [RW-1:0]         pix_row_q;
  logic [CW-1:0]         pix_col_q;
  logic                  pix_valid_q, pix_first_q, pix_last_q;
  logic                  frame_done_q;
  logic [CNT_W-1:0]      frame_count_q;

`ifdef AXIS_FRAME_SINK_TLAST_CHECK_EN
  frame_sink_state_t state_q;
  logic              err_early_q, err_missing_q;

  assign in_recv  = (state_q == RECV);
  assign s_tready = !in_recv || !pix_valid_q || pix_ready;
  // A tlast anywhere except on the kept final pixel ends the frame early,
  // including on a null beat.
  assign early    = accept && in_recv && s_tlast && !(s_tkeep && at_last);
  assign missing  = kept && at_last && !s_tlast;
  assign cnt_clr  = early || (kept && at_last);
  assign unused_inputs    = ^s_tstrb;
  assign err_early_last   = err_early_q;
  assign err_missing_last = err_missing_q;
`else
  assign in_recv  = 1'b1;
  assign s_tready = !pix_valid_q || pix_ready;
  assign early    = 1'b0;
  assign missing  = 1'b0;
  assign cnt_clr  = 1'b0;
  assign unused_inputs    = ^{s_tstrb, s_tlast};
  assign err_early_last   = 1'b0;
  assign err_missing_last = 1'b0;
`endif

  assign accept = s_tvalid && s_tready;
  assign kept   = accept && in_recv && s_tkeep;
  assign out_hs = pix_valid_q && pix_ready;

  axis_raster_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .en_i       (kept),
    .clr_i      (cnt_clr),
    .row_o      (row),
    .col_o      (col),
    .at_first_o (at_first),
    .at_last_o  (at_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      pix_data_q    <= '0;
      pix_row_q     <= '0;
      pix_col_q     <= '0;
      pix_valid_q   <= 1'b0;
      pix_first_q   <= 1'b0;
      pix_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
`ifdef AXIS_FRAME_SINK_TLAST_CHECK_EN
      state_q       <= RECV;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
`endif
    end else begin
      // kept only fires when the register is empty or draining this cycle
      if (kept) begin
        pix_data_q  <= s_tdata;
        pix_row_q   <= row;
        pix_col_q   <= col;
        pix_first_q <= at_first;
        pix_last_q  <= at_last || early;
        pix_valid_q <= 1'b1;
      end else if (pix_ready) begin
        pix_valid_q <= 1'b0;
      end
      frame_done_q <= out_hs && pix_last_q;
      if (out_hs && pix_last_q) frame_count_q <= frame_count_q + 1'b1;
`ifdef AXIS_FRAME_SINK_TLAST_CHECK_EN
      err_early_q   <= early;
      err_missing_q <= missing;
      case (state_q)
        RECV:    if (missing) state_q <= DISCARD;
        DISCARD: if (accept && s_tlast) state_q <= RECV;
        default: state_q <= RECV;
      endcase
`endif
    end
  end

  assign pix_data    = pix_data_q;
  assign pix_row     = pix_row_q;
  assign pix_col     = pix_col_q;
  assign pix_valid   = pix_valid_q;
  assign pix_first   = pix_first_q;
  assign pix_last    = pix_last_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

AXI-Stream receiving end for image frames entering the LeNet-5 datapath. It consumes a raster pixel stream on the peripheral (sink) side of `axis_if`, accepting `IMG_W*IMG_H` beats per frame. It tags each pixel with row/column coordinates and frame markers, checks `tlast` framing, and forwards pixels through one registered valid/ready stage to the first conv layer.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel width
- `IMG_W`, 28, pixels per row
- `IMG_H`, 28, rows per frame
- `CNT_W`, 16, `frame_count` width

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `s_tdata`  in  DATA_WIDTH  pixel
- `s_tvalid`  in  1  beat valid
- `s_tready`  out  1  beat accepted when `s_tvalid && s_tready`
- `s_tkeep`  in  1  0 = null beat
- `s_tstrb`  in  $clog2(DATA_WIDTH)  ignored
- `s_tlast`  in  1  final beat of frame
- `pix_data`  out  DATA_WIDTH  registered pixel
- `pix_valid`  out  1  output valid
- `pix_ready`  in  1  downstream ready
- `pix_row`  out  $clog2(IMG_H)  row of `pix_data`
- `pix_col`  out  $clog2(IMG_W)  column of `pix_data`
- `pix_first`  out  1  pixel (0,0)
- `pix_last`  out  1  pixel (IMG_H-1, IMG_W-1), or an early-`tlast` beat
- `frame_done`  out  1  1-cycle pulse on output handshake of a `pix_last` beat
- `err_early_last`  out  1  1-cycle pulse
- `err_missing_last`  out  1  1-cycle pulse
- `frame_count`  out  CNT_W  completed frames; wraps modulo 2^CNT_W

## Operation
- FSM states:
  - RECV: normal reception.
  - DISCARD: drop beats until `tlast`.
- Accept = `s_tvalid && s_tready`.
  - RECV: `s_tready = !pix_valid || pix_ready`.
  - DISCARD: `s_tready = 1`.
- Accepted beat in RECV with `s_tkeep=1`:
  - Loads the output register with data, current row/col, `pix_first = (row==0 && col==0)`, and `pix_last`.
  - Advances col; at `IMG_W-1`, col returns to 0 and row increments.
- Accepted beat with `s_tkeep=0`: consumed, not forwarded, counters unchanged. A `tlast` on a null beat is still checked.
- Framing checks, on an accepted beat in RECV:
  - `tlast=1` before the final pixel: pulse `err_early_last`. The beat is forwarded with `pix_last=1`. Counters clear to (0,0). Stay in RECV.
  - Final pixel with `tlast=0`: pulse `err_missing_last`. The beat is forwarded with `pix_last=1`. Counters clear. Go to DISCARD.
  - Final pixel with `tlast=1`: normal end of frame. Counters clear.
- DISCARD: beats are consumed and dropped. An accepted beat with `tlast=1` returns the FSM to RECV; that beat is also dropped.
- `frame_done` pulses and `frame_count` increments on every output handshake with `pix_last=1`, including error-terminated frames.
- Output register holds its contents while `pix_valid && !pix_ready`.
- Simultaneous output handshake and new accept: the register reloads in the same cycle, so there is no bubble.

## Timing
- Reset values:
  - FSM = RECV; row = col = 0.
  - All outputs 0, except `s_tready`, which is 1 in the cycle after reset deasserts.
- Latency: accept at cycle N gives `pix_valid` at N+1.
- Throughput: 1 pixel/cycle while `pix_ready=1`.
- `s_tready` depends combinationally on `pix_ready` and state only, never on `s_tvalid`.
- Error pulses are registered and assert in the cycle after the offending accept.
- Reset mid-frame: in-flight pixel discarded, `pix_valid` drops, counters cleared. The next accepted beat is (0,0).

## Configuration
- Macro: `AXIS_FRAME_SINK_TLAST_CHECK_EN`.
- Defined: framing checks, DISCARD state and both error pulses behave as above.
- Undefined:
  - `s_tlast` is ignored and frames are delimited purely by count.
  - `err_early_last` and `err_missing_last` are tied to 0.
  - DISCARD is not synthesized.

## Structure
- Shared package `axis_pkg` holds:
  - the `frame_sink_state_t` enum (RECV, DISCARD);
  - default `IMG_W`/`IMG_H` constants.
- Sub-module `axis_raster_counter`: row/col counter with an enable and a synchronous clear, plus `at_first`/`at_last` flags.

## Test plan
- Reset, then 784 beats with `tlast` on beat 783 and `pix_ready=1` → 784 outputs, first at (0,0) with `pix_first`, last at (27,27) with `pix_last`. One `frame_done`; `frame_count=1`; no error pulses.
- Same frame with `pix_ready` toggling 1/0 each cycle → identical data/row/col sequence, no loss or duplication, `s_tready` low whenever the output is stalled.
- `tlast` on beat 99 → `err_early_last` pulse, output 99 has `pix_last=1`. The next beat emerges at (0,0); `frame_count` increments.
- 800 beats, `tlast` only on beat 799 → `err_missing_last` after beat 783. Beats 784–799 consumed with no output; the next beat emerges at (0,0).
- Null beats (`tkeep=0`) interleaved every 3rd beat → null beats absent from the output, coordinates continuous, frame still completes at 784 kept beats.
- Reset asserted at pixel (10,5) with `pix_valid=1` → `pix_valid=0` the next cycle; the restarted frame begins at (0,0); `frame_count=0`.
